fifo_wr_arb: RTL and testbench

FIFO_WR_ARB -- requirements
Module: fifo_wr_arb

---
 rtl/fifo_wr_arb_pkg.sv | 17 +
 rtl/fifo_wr_arb_rr_pick.sv | 29 ++
 rtl/fifo_wr_arb.sv | 241 ++++++++++++++++++++++++
 tb/tb_fifo_wr_arb.sv | 269 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/fifo_wr_arb_pkg.sv
// fifo_wr_arb_pkg: shared types and constants for the FIFO write arbiter.
// Holds the arbiter state encoding, the statistics counter width and a
// saturating-increment helper used when FIFO_WR_ARB_STATS_EN is defined.
package fifo_wr_arb_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } arb_state_e;

  localparam int STATS_CNT_W = 16;

  function automatic logic [STATS_CNT_W-1:0] sat_inc(input logic [STATS_CNT_W-1:0] v);
    return (v == {STATS_CNT_W{1'b1}}) ? v : v + 1'b1;
  endfunction

endpackage

// File: rtl/fifo_wr_arb_rr_pick.sv
// rr_pick: round-robin picker. Returns a one-hot grant for the first set
// request bit at or after ptr, wrapping past N-1 back to 0.
module rr_pick #(
  parameter int N  = 4,
  parameter int PW = $clog2(N)
) (
  input  logic [N-1:0]  req,
  input  logic [PW-1:0] ptr,
  output logic [N-1:0]  gnt,
  output logic          valid
);

  int idx;

  // Scan from ptr upward (mod N) and keep only the first hit.
  always_comb begin
    gnt   = '0;
    valid = 1'b0;
    idx   = 0;
    for (int off = 0; off < N; off++) begin
      idx = (int'(ptr) + off) % N;
      if (!valid && req[idx[PW-1:0]]) begin
        gnt[idx[PW-1:0]] = 1'b1;
        valid            = 1'b1;
      end
    end
  end

endmodule

// File: rtl/fifo_wr_arb.sv
// fifo_wr_arb: packet-level round-robin arbiter feeding a downstream FIFO.
// Whole packets from one requester are forwarded before re-arbitrating;
// writes are credit-limited by the FIFO depth and registered one cycle.
// Optional per-requester packet counters: define FIFO_WR_ARB_STATS_EN.
module fifo_wr_arb
  import fifo_wr_arb_pkg::*;
#(
  parameter int NUM_REQ    = 4,
  parameter int DATA_WIDTH = 144,
  parameter int FIFO_DEPTH = 64
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic [NUM_REQ-1:0]              req_valid,
  input  logic [NUM_REQ-1:0]              req_sop,
  input  logic [NUM_REQ-1:0]              req_eop,
  input  logic [NUM_REQ*DATA_WIDTH-1:0]   req_data,
  output logic [NUM_REQ-1:0]              req_ready,
  output logic [DATA_WIDTH-1:0]           fifo_data,
  output logic                            fifo_wrreq,
  output logic [$clog2(NUM_REQ)-1:0]      fifo_src,
  input  logic                            fifo_rdreq,
  output logic [$clog2(FIFO_DEPTH):0]     credit,
  output logic                            idle,
  output logic                            err_credit,
  output logic                            err_proto,
`ifdef FIFO_WR_ARB_STATS_EN
  input  logic                            stats_clr,
  output logic [NUM_REQ*STATS_CNT_W-1:0]  grant_cnt,
`endif
  input  logic                            err_clr
);

  localparam int SRC_W  = $clog2(NUM_REQ);
  localparam int CRED_W = $clog2(FIFO_DEPTH) + 1;
  localparam logic [CRED_W-1:0] CREDIT_FULL = CRED_W'(FIFO_DEPTH);
  localparam logic [SRC_W-1:0]  LAST_REQ    = SRC_W'(NUM_REQ - 1);

  arb_state_e            state_q, state_d;
  logic [SRC_W-1:0]      rr_ptr_q, rr_ptr_d;
  logic [SRC_W-1:0]      gnt_q, gnt_d;
  logic                  first_q, first_d;
  logic [CRED_W-1:0]     credit_q, credit_d;
  logic                  fifo_wrreq_q, fifo_wrreq_d;
  logic [DATA_WIDTH-1:0] fifo_data_q, fifo_data_d;
  logic [SRC_W-1:0]      fifo_src_q, fifo_src_d;
  logic                  err_credit_q, err_credit_d;
  logic                  err_proto_q, err_proto_d;

  logic                  credit_nz;
  logic                  credit_full;
  logic [NUM_REQ-1:0]    pick_req;
  logic [NUM_REQ-1:0]    pick_oh;
  logic                  pick_valid;
  logic [SRC_W-1:0]      pick_idx;
  logic                  accept;
  logic                  cur_sop;
  logic                  cur_eop;
  logic [DATA_WIDTH-1:0] cur_data;
  logic                  credit_ovf;
  logic                  proto_viol;

  assign credit_nz   = (credit_q != '0);
  assign credit_full = (credit_q == CREDIT_FULL);

  // Only packet starts compete, and only while the FIFO has room.
  always_comb begin
    pick_req = '0;
    if (state_q == IDLE && credit_nz) begin
      pick_req = req_valid & req_sop;
    end
  end

  rr_pick #(
    .N  (NUM_REQ),
    .PW (SRC_W)
  ) u_rr_pick (
    .req   (pick_req),
    .ptr   (rr_ptr_q),
    .gnt   (pick_oh),
    .valid (pick_valid)
  );

  // Convert the one-hot pick into a requester index.
  always_comb begin
    pick_idx = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (pick_oh[i]) begin
        pick_idx = SRC_W'(i);
      end
    end
  end

  // Select the granted requester's beat and decide whether it transfers.
  always_comb begin
    cur_sop  = req_sop[gnt_q];
    cur_eop  = req_eop[gnt_q];
    cur_data = req_data[int'(gnt_q)*DATA_WIDTH +: DATA_WIDTH];
    accept   = (state_q == BUSY) && credit_nz && req_valid[gnt_q];
  end

  // Only the granted requester sees ready, and only in BUSY with credit.
  always_comb begin
    req_ready = '0;
    if (state_q == BUSY && credit_nz) begin
      req_ready[gnt_q] = 1'b1;
    end
  end

  // Arbitration FSM: grant in IDLE, forward beats in BUSY until eop.
  always_comb begin
    state_d  = state_q;
    gnt_d    = gnt_q;
    rr_ptr_d = rr_ptr_q;
    first_d  = first_q;
    case (state_q)
      IDLE: begin
        if (pick_valid) begin
          gnt_d   = pick_idx;
          first_d = 1'b1;
          state_d = BUSY;
        end
      end
      BUSY: begin
        if (accept) begin
          first_d = 1'b0;
          if (cur_eop) begin
            rr_ptr_d = (gnt_q == LAST_REQ) ? '0 : gnt_q + 1'b1;
            state_d  = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Credit pool: a write consumes one, a pop returns one; popping a full pool is an error.
  always_comb begin
    credit_d   = credit_q;
    credit_ovf = 1'b0;
    case ({accept, fifo_rdreq})
      2'b10: credit_d = credit_q - 1'b1;
      2'b01: begin
        if (credit_full) begin
          credit_ovf = 1'b1;
        end else begin
          credit_d = credit_q + 1'b1;
        end
      end
      default: credit_d = credit_q;
    endcase
  end

  // Registered write port; data and source hold when nothing is written.
  always_comb begin
    fifo_wrreq_d = accept;
    fifo_data_d  = fifo_data_q;
    fifo_src_d   = fifo_src_q;
    if (accept) begin
      fifo_data_d = cur_data;
      fifo_src_d  = gnt_q;
    end
  end

  // Sticky error flags; a new error in the clearing cycle keeps the flag set.
  always_comb begin
    proto_viol   = accept && cur_sop && !first_q;
    err_credit_d = credit_ovf ? 1'b1 : (err_clr ? 1'b0 : err_credit_q);
    err_proto_d  = proto_viol ? 1'b1 : (err_clr ? 1'b0 : err_proto_q);
  end

  // State, datapath and flag registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      rr_ptr_q     <= '0;
      gnt_q        <= '0;
      first_q      <= 1'b0;
      credit_q     <= CREDIT_FULL;
      fifo_wrreq_q <= 1'b0;
      fifo_data_q  <= '0;
      fifo_src_q   <= '0;
      err_credit_q <= 1'b0;
      err_proto_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      rr_ptr_q     <= rr_ptr_d;
      gnt_q        <= gnt_d;
      first_q      <= first_d;
      credit_q     <= credit_d;
      fifo_wrreq_q <= fifo_wrreq_d;
      fifo_data_q  <= fifo_data_d;
      fifo_src_q   <= fifo_src_d;
      err_credit_q <= err_credit_d;
      err_proto_q  <= err_proto_d;
    end
  end

  assign fifo_wrreq = fifo_wrreq_q;
  assign fifo_data  = fifo_data_q;
  assign fifo_src   = fifo_src_q;
  assign credit     = credit_q;
  assign err_credit = err_credit_q;
  assign err_proto  = err_proto_q;
  assign idle       = (state_q == IDLE) && credit_full;

`ifdef FIFO_WR_ARB_STATS_EN
  logic [STATS_CNT_W-1:0] cnt_q [NUM_REQ];
  logic [STATS_CNT_W-1:0] cnt_d [NUM_REQ];

  // Count completed packets per requester, saturating at all-ones.
  always_comb begin
    for (int i = 0; i < NUM_REQ; i++) begin
      cnt_d[i] = cnt_q[i];
      if (stats_clr) begin
        cnt_d[i] = '0;
      end else if (accept && cur_eop && (gnt_q == SRC_W'(i))) begin
        cnt_d[i] = sat_inc(cnt_q[i]);
      end
    end
  end

  // Packet counter registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NUM_REQ; i++) begin
        cnt_q[i] <= '0;
      end
    end else begin
      for (int i = 0; i < NUM_REQ; i++) begin
        cnt_q[i] <= cnt_d[i];
      end
    end
  end

  for (genvar g = 0; g < NUM_REQ; g++) begin : g_cnt
    assign grant_cnt[g*STATS_CNT_W +: STATS_CNT_W] = cnt_q[g];
  end
`endif

endmodule

// File: tb/tb_fifo_wr_arb.sv
// tb_fifo_wr_arb: directed self-checking bench for fifo_wr_arb (default parameters).
module tb_fifo_wr_arb;

  localparam int NR = 4;
  localparam int DW = 144;

  logic             clk;
  logic             rst;
  logic [NR-1:0]    req_valid;
  logic [NR-1:0]    req_sop;
  logic [NR-1:0]    req_eop;
  logic [NR*DW-1:0] req_data;
  logic [NR-1:0]    req_ready;
  logic [DW-1:0]    fifo_data;
  logic             fifo_wrreq;
  logic [1:0]       fifo_src;
  logic             fifo_rdreq;
  logic [6:0]       credit;
  logic             idle;
  logic             err_credit;
  logic             err_proto;
  logic             err_clr;

  int checks;
  int errors;

  fifo_wr_arb dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_sop    (req_sop),
    .req_eop    (req_eop),
    .req_data   (req_data),
    .req_ready  (req_ready),
    .fifo_data  (fifo_data),
    .fifo_wrreq (fifo_wrreq),
    .fifo_src   (fifo_src),
    .fifo_rdreq (fifo_rdreq),
    .credit     (credit),
    .idle       (idle),
    .err_credit (err_credit),
    .err_proto  (err_proto),
    .err_clr    (err_clr)
  );

  // 10 ns clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one clock and settle just past the rising edge
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic setLane(input int i, input logic [DW-1:0] v);
    req_data[i*DW +: DW] = v;
  endtask

  // Drive all requester/consumer inputs, then let combinational outputs settle
  task automatic applyStimulus(input logic [NR-1:0] v, input logic [NR-1:0] s,
                               input logic [NR-1:0] e, input logic rd, input logic clr);
    req_valid  = v;
    req_sop    = s;
    req_eop    = e;
    fifo_rdreq = rd;
    err_clr    = clr;
    #1;
  endtask

  // Compare one observed value against its hand-computed expectation
  task automatic checkOutput(input string tag, input logic [159:0] observed,
                             input logic [159:0] expected);
    checks++;
    assert (observed === expected)
      else begin
        errors++;
        $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
      end
  endtask

  // Directed test sequence
  initial begin
    checks = 0;
    errors = 0;
    rst = 1'b1;
    req_data = '0;
    applyStimulus(4'b0000, 4'b0000, 4'b0000, 1'b0, 1'b0);
    tick();
    tick();

    // Reset state
    checkOutput("rst_wrreq", fifo_wrreq, 0);
    checkOutput("rst_data", fifo_data, 0);
    checkOutput("rst_src", fifo_src, 0);
    checkOutput("rst_ready", req_ready, 0);
    checkOutput("rst_credit", credit, 64);
    checkOutput("rst_idle", idle, 1);
    checkOutput("rst_err_credit", err_credit, 0);
    checkOutput("rst_err_proto", err_proto, 0);
    rst = 1'b0;

    // Req0 three-beat packet
    $display("[TB] req0 3-beat packet");
    setLane(0, 144'hA1);
    applyStimulus(4'b0001, 4'b0001, 4'b0000, 1'b0, 1'b0);
    checkOutput("t1_idle_ready", req_ready, 4'b0000);
    tick();
    checkOutput("t1_busy_ready", req_ready, 4'b0001);
    checkOutput("t1_no_wr_yet", fifo_wrreq, 0);
    tick();
    checkOutput("t1_b1_wrreq", fifo_wrreq, 1);
    checkOutput("t1_b1_data", fifo_data, 144'hA1);
    checkOutput("t1_b1_src", fifo_src, 0);
    checkOutput("t1_b1_credit", credit, 63);
    setLane(0, 144'hA2);
    applyStimulus(4'b0001, 4'b0000, 4'b0000, 1'b0, 1'b0);
    tick();
    checkOutput("t1_b2_data", fifo_data, 144'hA2);
    checkOutput("t1_b2_credit", credit, 62);
    setLane(0, 144'hA3);
    applyStimulus(4'b0001, 4'b0000, 4'b0001, 1'b0, 1'b0);
    tick();
    checkOutput("t1_b3_wrreq", fifo_wrreq, 1);
    checkOutput("t1_b3_data", fifo_data, 144'hA3);
    checkOutput("t1_b3_credit", credit, 61);
    checkOutput("t1_eop_ready", req_ready, 4'b0000);
    applyStimulus(4'b0000, 4'b0000, 4'b0000, 1'b0, 1'b0);
    tick();
    checkOutput("t1_after_wrreq", fifo_wrreq, 0);
    checkOutput("t1_after_data_hold", fifo_data, 144'hA3);
    checkOutput("t1_err_proto", err_proto, 0);

    // Req0 and req2 contend with rr_ptr=1: req2 first
    $display("[TB] round-robin req0/req2");
    setLane(0, 144'hB0);
    setLane(2, 144'hB2);
    applyStimulus(4'b0101, 4'b0101, 4'b0101, 1'b0, 1'b0);
    tick();
    checkOutput("t2_gnt_req2", req_ready, 4'b0100);
    tick();
    checkOutput("t2_req2_src", fifo_src, 2);
    checkOutput("t2_req2_data", fifo_data, 144'hB2);
    applyStimulus(4'b0001, 4'b0001, 4'b0001, 1'b0, 1'b0);
    checkOutput("t2_idle_ready", req_ready, 4'b0000);
    tick();
    checkOutput("t2_gnt_req0", req_ready, 4'b0001);
    checkOutput("t2_gap_wrreq", fifo_wrreq, 0);
    tick();
    checkOutput("t2_req0_src", fifo_src, 0);
    checkOutput("t2_req0_data", fifo_data, 144'hB0);
    checkOutput("t2_credit", credit, 59);

    // Long req1 packet drains the credit pool; pop during accept at credit 10
    $display("[TB] credit exhaustion");
    setLane(1, 144'hC1);
    applyStimulus(4'b0010, 4'b0010, 4'b0000, 1'b0, 1'b0);
    tick();
    checkOutput("t3_gnt_req1", req_ready, 4'b0010);
    tick();
    applyStimulus(4'b0010, 4'b0000, 4'b0000, 1'b0, 1'b0);
    for (int k = 1; k < 49; k++) tick();
    checkOutput("t3_credit_10", credit, 10);
    applyStimulus(4'b0010, 4'b0000, 4'b0000, 1'b1, 1'b0);
    tick();
    checkOutput("t3_acc_pop_credit", credit, 10);
    checkOutput("t3_acc_pop_wrreq", fifo_wrreq, 1);
    applyStimulus(4'b0010, 4'b0000, 4'b0000, 1'b0, 1'b0);
    for (int k = 0; k < 10; k++) tick();
    checkOutput("t3_credit_0", credit, 0);
    checkOutput("t3_ready_low", req_ready, 4'b0000);
    checkOutput("t3_not_idle", idle, 0);
    checkOutput("t3_err_proto", err_proto, 0);
    tick();
    checkOutput("t3_stall_wrreq", fifo_wrreq, 0);
    applyStimulus(4'b0010, 4'b0000, 4'b0000, 1'b1, 1'b0);
    tick();
    checkOutput("t3_pop_credit_1", credit, 1);
    setLane(1, 144'hC2);
    applyStimulus(4'b0010, 4'b0000, 4'b0000, 1'b0, 1'b0);
    checkOutput("t3_ready_back", req_ready, 4'b0010);
    tick();
    checkOutput("t3_one_more_wrreq", fifo_wrreq, 1);
    checkOutput("t3_one_more_data", fifo_data, 144'hC2);
    checkOutput("t3_one_more_credit", credit, 0);
    applyStimulus(4'b0010, 4'b0000, 4'b0010, 1'b1, 1'b0);
    tick();
    applyStimulus(4'b0010, 4'b0000, 4'b0010, 1'b0, 1'b0);
    tick();
    checkOutput("t3_eop_credit", credit, 0);
    applyStimulus(4'b0000, 4'b0000, 4'b0000, 1'b1, 1'b0);
    for (int k = 0; k < 64; k++) tick();
    checkOutput("t3_refill_credit", credit, 64);
    checkOutput("t3_refill_idle", idle, 1);
    checkOutput("t3_refill_err", err_credit, 0);

    // Credit overflow error and clear priority
    $display("[TB] credit overflow");
    tick();
    checkOutput("t4_ovf_credit", credit, 64);
    checkOutput("t4_ovf_err", err_credit, 1);
    applyStimulus(4'b0000, 4'b0000, 4'b0000, 1'b1, 1'b1);
    tick();
    checkOutput("t4_set_wins", err_credit, 1);
    applyStimulus(4'b0000, 4'b0000, 4'b0000, 1'b0, 1'b1);
    tick();
    checkOutput("t4_cleared", err_credit, 0);
    applyStimulus(4'b0000, 4'b0000, 4'b0000, 1'b0, 1'b0);

    // Valid without sop is held; sop mid-packet flags err_proto (rr_ptr=2)
    $display("[TB] protocol checks");
    setLane(3, 144'hD1);
    applyStimulus(4'b1000, 4'b0000, 4'b0000, 1'b0, 1'b0);
    tick();
    checkOutput("t5_nosop_ready", req_ready, 4'b0000);
    checkOutput("t5_nosop_wrreq", fifo_wrreq, 0);
    applyStimulus(4'b1000, 4'b1000, 4'b0000, 1'b0, 1'b0);
    tick();
    checkOutput("t5_gnt_req3", req_ready, 4'b1000);
    tick();
    checkOutput("t5_first_sop_ok", err_proto, 0);
    checkOutput("t5_src3", fifo_src, 3);
    setLane(3, 144'hD2);
    applyStimulus(4'b1000, 4'b1000, 4'b0000, 1'b0, 1'b0);
    tick();
    checkOutput("t5_err_proto", err_proto, 1);
    checkOutput("t5_sop_accepted", fifo_data, 144'hD2);
    setLane(3, 144'hD3);
    applyStimulus(4'b1000, 4'b0000, 4'b1000, 1'b0, 1'b0);
    tick();
    checkOutput("t5_credit", credit, 61);

    // Reset during beat 2 of a req2 packet, then re-arbitrate from req0
    $display("[TB] mid-packet reset");
    setLane(2, 144'hE1);
    applyStimulus(4'b0100, 4'b0100, 4'b0000, 1'b0, 1'b0);
    tick();
    tick();
    checkOutput("t6_b1_src", fifo_src, 2);
    checkOutput("t6_b1_credit", credit, 60);
    setLane(2, 144'hE2);
    applyStimulus(4'b0100, 4'b0000, 4'b0000, 1'b0, 1'b0);
    rst = 1'b1;
    #1;
    checkOutput("t6_rst_wrreq", fifo_wrreq, 0);
    checkOutput("t6_rst_data", fifo_data, 0);
    checkOutput("t6_rst_src", fifo_src, 0);
    checkOutput("t6_rst_ready", req_ready, 4'b0000);
    checkOutput("t6_rst_credit", credit, 64);
    checkOutput("t6_rst_idle", idle, 1);
    checkOutput("t6_rst_err_proto", err_proto, 0);
    tick();
    rst = 1'b0;
    setLane(0, 144'hF0);
    applyStimulus(4'b0101, 4'b0101, 4'b0101, 1'b0, 1'b0);
    tick();
    checkOutput("t6_regnt_req0", req_ready, 4'b0001);
    tick();
    checkOutput("t6_req0_src", fifo_src, 0);
    checkOutput("t6_req0_data", fifo_data, 144'hF0);
    checkOutput("t6_req0_wrreq", fifo_wrreq, 1);
    applyStimulus(4'b0000, 4'b0000, 4'b0000, 1'b0, 1'b0);
    tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
